// File: rtl/conv_relu_pool.sv
// conv_relu_pool
//   Downstream stage of the convolution engine. Captures one OUT_DIM x OUT_DIM
//   map of IEEE754 single-precision conv results, with optional ReLU applied as
//   each word is captured. It then max-pools the map over non-overlapping
//   POOL x POOL windows and emits one pooled word per window.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   COLLECT | accepting in_valid words into the buffer (busy=0)
//   POOL    | scanning one element of the current window per cycle
//   EMIT    | out_valid strobe for the finished window (one cycle)
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   in_data     IEEE754 conv result
//   in_valid    single-cycle strobe qualifying in_data
//   relu_en     1 = store negative inputs as +0.0 (sampled with in_data)
//   out_data    pooled word; holds its value until the next emit
//   out_valid   one-cycle strobe for out_data
//   frame_done  one-cycle strobe on the last out_valid of a frame
//   busy        high in POOL/EMIT; in_valid is not accepted then
//   dropped     sticky flag, set by in_valid while busy; cleared by rst
module conv_relu_pool #(
    parameter int OUT_DIM = 2,
    parameter int POOL    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    input  logic        relu_en,
    output logic [31:0] out_data,
    output logic        out_valid,
    output logic        frame_done,
    output logic        busy,
    output logic        dropped
);

    localparam int N    = OUT_DIM * OUT_DIM;
    localparam int NWIN = OUT_DIM / POOL;
    localparam int AW   = (N > 1) ? $clog2(N) : 1;
    localparam int PW   = (POOL > 1) ? $clog2(POOL) : 1;
    localparam int WW   = (NWIN > 1) ? $clog2(NWIN) : 1;

    typedef enum logic [1:0] {
        S_COLLECT,
        S_POOL,
        S_EMIT
    } state_t;

    state_t        state_q;
    logic [AW-1:0] wr_cnt_q;
    logic [WW-1:0] wr_q, wc_q;
    logic [PW-1:0] pr_q, pc_q;
    logic [31:0]   max_q, max_d;
    logic [31:0]   out_data_q;
    logic          out_valid_q, frame_done_q, dropped_q;
    logic [31:0]   buf_q [N];

    logic [31:0]   cap_d;
    logic [31:0]   elem;
    logic [AW-1:0] rd_addr;
    logic          accept;
    logic          first_elem, last_elem, last_win;

    // Strict sign-magnitude "a > b". +0 and -0 are equal, so neither wins and
    // the earlier element stays as the running max.
    function automatic logic fp_gt(input logic [31:0] a, input logic [31:0] b);
        logic r;
        if (a[30:0] == 31'd0 && b[30:0] == 31'd0) begin
            r = 1'b0;
        end else if (a[31] != b[31]) begin
            r = ~a[31];
        end else if (!a[31]) begin
            r = (a[30:0] > b[30:0]);
        end else begin
            r = (a[30:0] < b[30:0]);
        end
        return r;
    endfunction

    assign accept = in_valid && (state_q == S_COLLECT);
    assign cap_d  = (relu_en && in_data[31]) ? 32'h0000_0000 : in_data;

    assign rd_addr = AW'((int'(wr_q) * POOL + int'(pr_q)) * OUT_DIM
                         + int'(wc_q) * POOL + int'(pc_q));
    assign elem    = buf_q[rd_addr];

    assign first_elem = (pr_q == '0) && (pc_q == '0);
    assign last_elem  = (pr_q == PW'(POOL - 1)) && (pc_q == PW'(POOL - 1));
    assign last_win   = (wr_q == WW'(NWIN - 1)) && (wc_q == WW'(NWIN - 1));

    always_comb begin
        max_d = max_q;
        if (first_elem || fp_gt(elem, max_q)) begin
            max_d = elem;
        end
    end

    // Buffer contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            buf_q[wr_cnt_q] <= cap_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_COLLECT;
            wr_cnt_q     <= '0;
            wr_q         <= '0;
            wc_q         <= '0;
            pr_q         <= '0;
            pc_q         <= '0;
            max_q        <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            dropped_q    <= 1'b0;
        end else begin
            if (in_valid && state_q != S_COLLECT) begin
                dropped_q <= 1'b1;
            end
            case (state_q)
                S_COLLECT: begin
                    if (in_valid) begin
                        if (wr_cnt_q == AW'(N - 1)) begin
                            wr_cnt_q <= '0;
                            state_q  <= S_POOL;
                        end else begin
                            wr_cnt_q <= wr_cnt_q + 1'b1;
                        end
                    end
                end
                S_POOL: begin
                    max_q <= max_d;
                    if (last_elem) begin
                        // Final max goes straight to the output register so
                        // it is visible during the EMIT cycle.
                        pr_q         <= '0;
                        pc_q         <= '0;
                        out_data_q   <= max_d;
                        out_valid_q  <= 1'b1;
                        frame_done_q <= last_win;
                        state_q      <= S_EMIT;
                    end else if (pc_q == PW'(POOL - 1)) begin
                        pc_q <= '0;
                        pr_q <= pr_q + 1'b1;
                    end else begin
                        pc_q <= pc_q + 1'b1;
                    end
                end
                S_EMIT: begin
                    out_valid_q  <= 1'b0;
                    frame_done_q <= 1'b0;
                    if (last_win) begin
                        wr_q    <= '0;
                        wc_q    <= '0;
                        state_q <= S_COLLECT;
                    end else begin
                        if (wc_q == WW'(NWIN - 1)) begin
                            wc_q <= '0;
                            wr_q <= wr_q + 1'b1;
                        end else begin
                            wc_q <= wc_q + 1'b1;
                        end
                        state_q <= S_POOL;
                    end
                end
                default: state_q <= S_COLLECT;
            endcase
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != S_COLLECT);
    assign dropped    = dropped_q;

endmodule

// File: doc/conv_relu_pool.md
Name: conv_relu_pool

Overview:
- Downstream stage of the convolution engine.
- Captures each IEEE754 single-precision convolution result on its completion strobe, with optional ReLU applied at capture.
- Holds one complete output feature map, then runs non-overlapping PxP max-pooling over it.
- Emits pooled words one at a time with a single-cycle valid strobe, for the next layer or the output writer.

Parameters:
- OUT_DIM, 2, side length of the square conv output map, in words; must be a multiple of POOL.
- POOL, 2, pooling window side; pooling stride equals POOL.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_data  input  32  IEEE754 single conv result; connects to conv out
- in_valid  input  1  single-cycle strobe, in_data valid; connects to conv done
- relu_en  input  1  1 = clamp negative inputs to +0.0; sampled together with in_data
- out_data  output  32  pooled IEEE754 word
- out_valid  output  1  one-cycle strobe, out_data valid
- frame_done  output  1  one-cycle strobe coincident with the last out_valid of a frame
- busy  output  1  high while pooling/emitting; in_valid not accepted
- dropped  output  1  sticky; set when in_valid arrives while busy; cleared only by rst

Behaviour:
- Reset (rst=1 at clk edge):
  - state=COLLECT; write counter, window and element counters = 0.
  - out_data=0, out_valid=0, frame_done=0, busy=0, dropped=0.
  - Buffer contents are don't-care.
  - Reset mid-frame abandons the partial frame; no output is produced for it.
- Storage: OUT_DIM*OUT_DIM x 32 register buffer, filled row-major (address = row*OUT_DIM+col in arrival order).
- ReLU at capture: if relu_en=1 and in_data[31]=1, store 32'h00000000 (this also maps -0.0 to +0.0). Otherwise store in_data unchanged.
- COLLECT state:
  - busy=0.
  - Each cycle with in_valid=1 writes the buffer at the write counter, then increments the counter.
  - On the write of element OUT_DIM*OUT_DIM-1: counter wraps to 0, next state=POOL.
- POOL state:
  - busy=1.
  - Windows are visited row-major (wr, wc), each 0..OUT_DIM/POOL-1.
  - Elements within a window are visited row-major (pr, pc), each 0..POOL-1; buffer address = (wr*POOL+pr)*OUT_DIM + wc*POOL+pc.
  - One element per cycle. Element 0 loads the running max; each later element replaces the max only if strictly greater.
  - After the last element, next state=EMIT.
- EMIT state (1 cycle):
  - out_valid=1, out_data=max.
  - If this is the last window, frame_done=1 and next state=COLLECT; otherwise advance the window and return to POOL.
  - out_data holds its value until the next emit.
- Compare rule (sign-magnitude ordering, no NaN special case):
  - Both signs 0: larger unsigned bits is greater.
  - Both signs 1: smaller unsigned [30:0] is greater.
  - Sign 0 beats sign 1, except +0/-0 compare equal; on equality the earlier element is retained.
- Timing: last accepted in_valid at cycle t → first out_valid at t+POOL*POOL+1. Subsequent out_valid strobes every POOL*POOL+1 cycles. With defaults: t+5.
- A new frame is accepted from the cycle after frame_done.
- in_valid while busy=1 (POOL or EMIT): data ignored, buffer unchanged, dropped<=1.
- relu_en changing mid-frame takes effect per captured word.

Test Plan:
- Defaults, relu_en=1, inputs 3F800000, C0400000, 40000000, 3F000000 on consecutive cycles (last at t) → out_valid and frame_done at t+5, out_data=40000000, busy high t+1..t+5.
- Defaults, relu_en=0, inputs BF800000, C0400000, BF000000, BF800000 → out_data=BF000000. Repeat with relu_en=1 → out_data=00000000.
- OUT_DIM=4, relu_en=0, row-major 1.0..16.0 → out_data sequence 40C00000, 41000000, 41600000, 41800000, spaced 5 cycles apart; frame_done only with the 4th.
- Defaults, in_valid pulsed during POOL with 7F000000 → no effect on result, dropped=1 and remains 1. A following frame of 3F800000 x4 → out_data=3F800000.
- Defaults, rst asserted after 2 inputs → all outputs 0, dropped=0. A fresh 4 inputs 3F000000, 3F800000, 40000000, 3F800000 → single out_data=40000000.
- Defaults, relu_en=0, inputs 80000000, 00000000, 80000000, 80000000 → out_data=80000000 (equal compare keeps first).
